// File: rtl/atten_pkg.sv
// Shared defaults and FSM state encoding for the attenuator ramp scheduler.
package atten_pkg;
    localparam int          ATTEN_NUM_BANDS  = 13;
    localparam int          ATTEN_GAIN_WIDTH = 16;
    localparam logic [15:0] ATTEN_RESET_GAIN = 16'h4000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } atten_state_e;
endpackage

// File: rtl/atten_ramp_step.sv
// One-band gain step toward target, clamped so the result never overshoots or wraps.
// Purely combinational (zero latency); no flow control.
module atten_ramp_step
    import atten_pkg::*;
#(
    parameter int GAIN_WIDTH = ATTEN_GAIN_WIDTH
) (
    input  logic [GAIN_WIDTH-1:0] cur_i,
    input  logic [GAIN_WIDTH-1:0] tgt_i,
    input  logic [GAIN_WIDTH-1:0] step_i,
    output logic [GAIN_WIDTH-1:0] nxt_o
);
    logic [GAIN_WIDTH:0] up_sum;
    logic [GAIN_WIDTH:0] dn_diff;
    logic [GAIN_WIDTH:0] tgt_ext;

    always_comb begin
        tgt_ext = {1'b0, tgt_i};
        up_sum  = {1'b0, cur_i} + {1'b0, step_i};
        dn_diff = {1'b0, cur_i} - {1'b0, step_i};
        nxt_o   = cur_i;
        if (step_i == '0) begin
            nxt_o = tgt_i;
        end else if (cur_i < tgt_i) begin
            nxt_o = (up_sum > tgt_ext) ? tgt_i : up_sum[GAIN_WIDTH-1:0];
        end else if (cur_i > tgt_i) begin
            // Top bit set means the subtraction borrowed below zero.
            nxt_o = (dn_diff[GAIN_WIDTH] || (dn_diff < tgt_ext)) ? tgt_i : dn_diff[GAIN_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/atten_ramp_scheduler.sv
// Ramps NUM_BANDS gains toward targets, one band per cycle; a pass is NUM_BANDS SCAN cycles + 1 DONE cycle.
// No backpressure: one tick during a pass is held pending, further ticks drop with tickOverrun. ATTEN_RAMP_SETTLED_EN adds settled[].
module atten_ramp_scheduler
    import atten_pkg::*;
#(
    parameter int                    NUM_BANDS  = ATTEN_NUM_BANDS,
    parameter int                    GAIN_WIDTH = ATTEN_GAIN_WIDTH,
    parameter logic [GAIN_WIDTH-1:0] RESET_GAIN = GAIN_WIDTH'(ATTEN_RESET_GAIN)
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic                            sampleTick,
    input  logic [NUM_BANDS*GAIN_WIDTH-1:0] targetFlat,
    input  logic [GAIN_WIDTH-1:0]           stepSize,
    output logic [NUM_BANDS*GAIN_WIDTH-1:0] gainFlat,
    output logic [3:0]                      bandIdx,
    output logic                            busy,
    output logic                            passDone,
    output logic                            tickOverrun
`ifdef ATTEN_RAMP_SETTLED_EN
    ,
    output logic [NUM_BANDS-1:0]            settled
`endif
);
    localparam logic [3:0] LAST_BAND = 4'(NUM_BANDS - 1);

    atten_state_e          state_q, state_d;
    logic [3:0]            bandIdx_q, bandIdx_d;
    logic                  pending_q, pending_d;
    logic                  overrun_q, overrun_d;
    logic                  band_we;
    logic [GAIN_WIDTH-1:0] gain_q  [NUM_BANDS];
    logic [GAIN_WIDTH-1:0] tgt_arr [NUM_BANDS];
    logic [GAIN_WIDTH-1:0] cur_band, tgt_band, nxt_band;

    for (genvar k = 0; k < NUM_BANDS; k++) begin : g_band
        assign tgt_arr[k] = targetFlat[GAIN_WIDTH*k +: GAIN_WIDTH];
        assign gainFlat[GAIN_WIDTH*k +: GAIN_WIDTH] = gain_q[k];
    end

    assign cur_band = gain_q[bandIdx_q];
    assign tgt_band = tgt_arr[bandIdx_q];

    atten_ramp_step #(.GAIN_WIDTH(GAIN_WIDTH)) u_step (
        .cur_i  (cur_band),
        .tgt_i  (tgt_band),
        .step_i (stepSize),
        .nxt_o  (nxt_band)
    );

    always_comb begin
        state_d   = state_q;
        bandIdx_d = bandIdx_q;
        pending_d = pending_q;
        overrun_d = 1'b0;
        band_we   = 1'b0;
        // A tick while busy is remembered once; a second one is lost.
        if (state_q != ST_IDLE && sampleTick) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (sampleTick || pending_q) begin
                    state_d   = ST_SCAN;
                    bandIdx_d = '0;
                    pending_d = 1'b0;
                end
            end
            ST_SCAN: begin
                band_we = 1'b1;
                if (bandIdx_q == LAST_BAND) state_d = ST_DONE;
                else                        bandIdx_d = bandIdx_q + 4'd1;
            end
            ST_DONE: begin
                if (pending_q) begin
                    state_d   = ST_SCAN;
                    bandIdx_d = '0;
                    pending_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q   <= ST_IDLE;
            bandIdx_q <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < NUM_BANDS; k++) gain_q[k] <= RESET_GAIN;
        end else begin
            state_q   <= state_d;
            bandIdx_q <= bandIdx_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            if (band_we) gain_q[bandIdx_q] <= nxt_band;
        end
    end

`ifdef ATTEN_RAMP_SETTLED_EN
    logic [NUM_BANDS-1:0] settled_q;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) settled_q <= '1;
        else if (band_we)   settled_q[bandIdx_q] <= (nxt_band == tgt_band);
    end

    assign settled = settled_q;
`endif

    assign bandIdx     = bandIdx_q;
    assign busy        = (state_q != ST_IDLE);
    assign passDone    = (state_q == ST_DONE);
    assign tickOverrun = overrun_q;
endmodule

// File: tb/tb_atten_ramp_scheduler.sv
// Scoreboard bench: each issued tick pushes the predicted end-of-pass gains and DONE cycle; a negedge monitor pops on passDone.
`timescale 1ns/1ps
module tb_atten_ramp_scheduler;
    localparam int NB = 13;
    localparam int GW = 16;
    localparam int FW = NB * GW;

    typedef struct {
        logic [FW-1:0] g;
        int            cyc;
    } exp_t;

    logic          S_AXI_ACLK;
    logic          S_AXI_ARESETN;
    logic          sampleTick;
    logic [FW-1:0] targetFlat;
    logic [GW-1:0] stepSize;
    logic [FW-1:0] gainFlat;
    logic [3:0]    bandIdx;
    logic          busy;
    logic          passDone;
    logic          tickOverrun;

    int            checks  = 0;
    int            errors  = 0;
    int            cyc     = 0;
    int            ovr_cnt = 0;
    exp_t          sb[$];
    exp_t          mon_e;
    logic [FW-1:0] model_g;

    atten_ramp_scheduler dut (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .sampleTick    (sampleTick),
        .targetFlat    (targetFlat),
        .stepSize      (stepSize),
        .gainFlat      (gainFlat),
        .bandIdx       (bandIdx),
        .busy          (busy),
        .passDone      (passDone),
        .tickOverrun   (tickOverrun)
    );

    initial S_AXI_ACLK = 1'b0;
    always #5 S_AXI_ACLK = ~S_AXI_ACLK;
    always @(posedge S_AXI_ACLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: apply the ramp rule to bands 0..nb-1 using plain integer arithmetic.
    function automatic logic [FW-1:0] ramp(input logic [FW-1:0] cur, input logic [FW-1:0] tgt,
                                           input int step, input int nb);
        logic [FW-1:0] r;
        r = cur;
        for (int k = 0; k < nb; k++) begin
            int c;
            int t;
            int n;
            c = int'(cur[k*GW +: GW]);
            t = int'(tgt[k*GW +: GW]);
            if (step == 0)  n = t;
            else if (c < t) n = (c + step < t) ? c + step : t;
            else if (c > t) n = (c - step > t) ? c - step : t;
            else            n = c;
            r[k*GW +: GW] = GW'(n);
        end
        return r;
    endfunction

    always @(negedge S_AXI_ACLK) begin
        if (S_AXI_ARESETN) begin
            if (tickOverrun) ovr_cnt++;
            if (passDone) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_passDone: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("pass_done_cycle", FW'(cyc), FW'(mon_e.cyc));
                    check("pass_gains", gainFlat, mon_e.g);
                end
            end
        end
    end

    // mode 0: no extra ticks, 1: random extra ticks, 2: exactly two extra ticks mid-scan
    task automatic run_episode(input int mode);
        logic [FW-1:0] exp1, exp2;
        logic          mask [14];
        int            n_extra, probe, ovr0, budget, thresh, n_start;
        exp_t          e;
        n_extra = 0;
        thresh  = int'($urandom_range(0, 2)) * 12;
        for (int o = 0; o < 14; o++) begin
            if (o == 13)        mask[o] = 1'b0;
            else if (mode == 0) mask[o] = 1'b0;
            else if (mode == 2) mask[o] = (o == 3 || o == 8);
            else                mask[o] = (int'($urandom_range(0, 99)) < thresh);
            if (mask[o]) n_extra++;
        end
        probe   = int'($urandom_range(1, 13));
        ovr0    = ovr_cnt;
        n_start = cyc + 1;
        exp1    = ramp(model_g, targetFlat, int'(stepSize), NB);
        exp2    = ramp(exp1, targetFlat, int'(stepSize), NB);
        e.g = exp1; e.cyc = n_start + 13; sb.push_back(e);
        if (n_extra > 0) begin
            e.g = exp2; e.cyc = n_start + 27; sb.push_back(e);
        end
        sampleTick = 1'b1;
        @(posedge S_AXI_ACLK); #1;
        for (int o = 0; o <= 13; o++) begin
            if (o == probe) begin
                check("mid_pass_gains", gainFlat, ramp(model_g, targetFlat, int'(stepSize), o));
                check("busy_in_pass", FW'(busy), FW'(1));
            end
            sampleTick = mask[o];
            @(posedge S_AXI_ACLK); #1;
        end
        budget = 0;
        while (busy && budget < 40) begin
            @(posedge S_AXI_ACLK); #1;
            budget++;
        end
        check("pass_end_timeout", FW'(busy), FW'(0));
        @(posedge S_AXI_ACLK); #1;
        check("overrun_count", FW'(ovr_cnt - ovr0), FW'((n_extra > 1) ? n_extra - 1 : 0));
        check("scoreboard_drained", FW'(sb.size()), FW'(0));
        model_g = (n_extra > 0) ? exp2 : exp1;
    endtask

    task automatic randomize_cfg();
        for (int k = 0; k < NB; k++) begin
            logic [GW-1:0] cur;
            cur = model_g[k*GW +: GW];
            case ($urandom_range(0, 3))
                0:       targetFlat[k*GW +: GW] = cur;
                1:       targetFlat[k*GW +: GW] = cur + GW'($urandom_range(0, 255)) - 16'd128;
                default: targetFlat[k*GW +: GW] = GW'($urandom);
            endcase
        end
        case ($urandom_range(0, 4))
            0:       stepSize = '0;
            1:       stepSize = 16'hFFFF;
            2:       stepSize = GW'($urandom_range(1, 64));
            default: stepSize = GW'($urandom);
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int budget;
        S_AXI_ARESETN = 1'b0;
        sampleTick    = 1'b0;
        targetFlat    = {NB{16'h4000}};
        stepSize      = '0;
        model_g       = {NB{16'h4000}};
        repeat (3) @(posedge S_AXI_ACLK);
        #1;
        check("reset_gains", gainFlat, {NB{16'h4000}});
        check("reset_busy", FW'(busy), FW'(0));
        check("reset_passDone", FW'(passDone), FW'(0));
        check("reset_tickOverrun", FW'(tickOverrun), FW'(0));
        check("reset_bandIdx", FW'(bandIdx), FW'(0));
        S_AXI_ARESETN = 1'b1;
        @(posedge S_AXI_ACLK); #1;
        check("idle_gains", gainFlat, {NB{16'h4000}});
        check("idle_busy", FW'(busy), FW'(0));

        targetFlat[3*GW +: GW] = 16'h4100;
        stepSize = 16'h0040;
        for (int i = 0; i < 5; i++) begin
            run_episode(0);
            check("band3_ramp", FW'(gainFlat[3*GW +: GW]),
                  FW'(16'h4000 + 16'h0040 * ((i < 4) ? i + 1 : 4)));
        end

        targetFlat = {NB{16'h4000}};
        targetFlat[0 +: GW] = 16'h0010;
        stepSize = 16'hFFFF;
        run_episode(0);
        check("band0_no_wrap", FW'(gainFlat[0 +: GW]), FW'(16'h0010));

        stepSize = '0;
        targetFlat[12*GW +: GW] = 16'h1234;
        run_episode(0);
        check("band12_bypass", FW'(gainFlat[12*GW +: GW]), FW'(16'h1234));

        targetFlat = {NB{16'h5000}};
        stepSize = 16'h0100;
        run_episode(2);

        repeat (30) begin
            randomize_cfg();
            run_episode(1);
        end

        targetFlat = {NB{16'h1000}};
        stepSize = 16'h0100;
        sampleTick = 1'b1;
        @(posedge S_AXI_ACLK); #1;
        sampleTick = 1'b0;
        budget = 0;
        while (bandIdx != 4'd6 && budget < 30) begin
            @(posedge S_AXI_ACLK); #1;
            budget++;
        end
        check("reach_band6", FW'(bandIdx), FW'(6));
        S_AXI_ARESETN = 1'b0;
        #1;
        check("midpass_reset_gains", gainFlat, {NB{16'h4000}});
        check("midpass_reset_busy", FW'(busy), FW'(0));
        check("midpass_reset_bandIdx", FW'(bandIdx), FW'(0));
        sb.delete();
        model_g = {NB{16'h4000}};
        @(posedge S_AXI_ACLK); #1;
        S_AXI_ARESETN = 1'b1;
        repeat (3) @(posedge S_AXI_ACLK);
        #1;
        check("post_reset_idle", FW'(busy), FW'(0));
        check("post_reset_gains", gainFlat, {NB{16'h4000}});

        repeat (5) begin
            randomize_cfg();
            run_episode(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
